// File: rtl/glitch_mon_pkg.sv
// Shared types and helpers for the glitch/minimum-pulse-width monitor.
// The sample-path synchronizer is selected with the GLITCH_SYNC_EN macro (see glitch_chan).
package glitch_mon_pkg;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } mon_state_t;

  // Width of a gap counter that must be able to hold the value min_w.
  function automatic int gap_w(input int min_w);
    return $clog2(min_w + 1);
  endfunction

endpackage

// File: rtl/glitch_chan.sv
// One monitored channel: sample/edge registers, measurement FSM, gap counter,
// saturating pass/fail counters. GLITCH_SYNC_EN inserts a 2-flop synchronizer ahead of s_q.
module glitch_chan
  import glitch_mon_pkg::*;
#(
  parameter int MIN_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             active,
  input  logic             clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int GAP_W = gap_w(MIN_W);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_W);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s_d;
  logic s_q;
  logic prev_q;
  logic edge_det;

  mon_state_t state_q;
  mon_state_t state_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic hit_pass;
  logic hit_fail;

`ifdef GLITCH_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], sig};
  end

  assign s_d = sync_q[1];
`else
  assign s_d = sig;
`endif

  // Sample path runs regardless of enable or clear so edges are never stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      prev_q <= s_q;
    end
  end

  assign edge_det = s_q ^ prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_EDGE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // clr outranks everything, so a same-cycle edge never becomes a reference.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    hit_pass = 1'b0;
    hit_fail = 1'b0;
    if (clr) begin
      state_d = WAIT_EDGE;
      gap_d   = '0;
    end else if (!active) begin
      state_d = WAIT_EDGE;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          if (edge_det) begin
            state_d = MEASURE;
            gap_d   = GAP_ONE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            gap_d = GAP_ONE;
            if (gap_q >= GAP_MAX) hit_pass = 1'b1;
            else                  hit_fail = 1'b1;
          end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + GAP_ONE;
          end
        end
        default: state_d = WAIT_EDGE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else if (clr) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      err_pulse <= hit_fail;
      if (hit_fail) err_sticky <= 1'b1;
      if (hit_pass && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (hit_fail && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/glitch_monitor_mc.sv
// Multi-channel glitch monitor top: fans out enables and packs per-channel results.
// Define GLITCH_SYNC_EN to add a 2-flop synchronizer on every channel input.
module glitch_monitor_mc #(
  parameter int N_CH  = 4,
  parameter int MIN_W = 20,
  parameter int CNT_W = 16
) (
  input  logic                  C_clk,
  input  logic                  C_rst,
  input  logic [N_CH-1:0]       sig_in,
  input  logic                  C_en,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic                  clr,
  output logic [N_CH-1:0]       err_pulse,
  output logic [N_CH-1:0]       err_sticky,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt
);

  logic [N_CH-1:0] active;

  assign active = {N_CH{C_en}} & ch_mask;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    glitch_chan #(
      .MIN_W(MIN_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (C_clk),
      .rst       (C_rst),
      .sig       (sig_in[i]),
      .active    (active[i]),
      .clr       (clr),
      .err_pulse (err_pulse[i]),
      .err_sticky(err_sticky[i]),
      .pass_cnt  (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt  (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_glitch_monitor_mc.sv
// Directed self-checking bench for glitch_monitor_mc: a CNT_W=16 and a CNT_W=4 instance share stimulus.
// Latency expectations follow GLITCH_SYNC_EN when it is defined for the build.
module tb_glitch_monitor_mc;

`ifdef GLITCH_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sig_in;
  logic        c_en;
  logic [3:0]  ch_mask;
  logic        clr;
  logic [3:0]  err_pulse, err_sticky;
  logic [63:0] pass_cnt, fail_cnt;
  logic [3:0]  s_err_pulse, s_err_sticky;
  logic [15:0] s_pass_cnt, s_fail_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  glitch_monitor_mc #(.N_CH(4), .MIN_W(20), .CNT_W(16)) dut (
    .C_clk(clk), .C_rst(rst), .sig_in(sig_in), .C_en(c_en), .ch_mask(ch_mask), .clr(clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  glitch_monitor_mc #(.N_CH(4), .MIN_W(20), .CNT_W(4)) dut_s (
    .C_clk(clk), .C_rst(rst), .sig_in(sig_in), .C_en(c_en), .ch_mask(ch_mask), .clr(clr),
    .err_pulse(s_err_pulse), .err_sticky(s_err_sticky), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
  );

  // Inputs always change 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle(input int ch);
    sig_in[ch] = ~sig_in[ch];
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sig_in = '0; c_en = 1'b0; ch_mask = '0; clr = 1'b0;
    tick(3);
    vectors++;
    if (err_pulse !== 4'b0 || err_sticky !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got pulse=%b sticky=%b want 0000/0000", err_pulse, err_sticky);
    end
    vectors++;
    if (pass_cnt !== 64'd0 || fail_cnt !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_counts got pass=%h fail=%h want 0", pass_cnt, fail_cnt);
    end
    vectors++;
    if (s_pass_cnt !== 16'd0 || s_fail_cnt !== 16'd0 || s_err_sticky !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_small got pass=%h fail=%h sticky=%b want 0", s_pass_cnt, s_fail_cnt, s_err_sticky);
    end
    rst = 1'b0; c_en = 1'b1; ch_mask = 4'hF;
    tick(3);
  endtask

  task automatic test_basic_pass();
    for (int i = 0; i < 5; i++) begin
      toggle(0);
      tick(25);
    end
    vectors++;
    if (pass_cnt[15:0] !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL basic_pass0 got %0d want 4", pass_cnt[15:0]);
    end
    vectors++;
    if (fail_cnt[15:0] !== 16'd0 || err_sticky !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_nofail got fail=%0d sticky=%b want 0/0000", fail_cnt[15:0], err_sticky);
    end
  endtask

  task automatic test_glitch();
    do_clr();
    toggle(1);
    tick(30);
    toggle(1);
    tick(3);
    toggle(1);
    tick(LAT - 1);
    @(negedge clk);
    vectors++;
    if (err_pulse !== 4'b0000 || err_sticky !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL glitch_pre got pulse=%b sticky=%b want 0000/0000", err_pulse, err_sticky);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (err_pulse !== 4'b0010 || err_sticky !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL glitch_pulse got pulse=%b sticky=%b want 0010/0010", err_pulse, err_sticky);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (err_pulse !== 4'b0000 || err_sticky !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL glitch_post got pulse=%b sticky=%b want 0000/0010", err_pulse, err_sticky);
    end
    tick(5);
    vectors++;
    if (pass_cnt[31:16] !== 16'd1 || fail_cnt[31:16] !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL glitch_counts got pass=%0d fail=%0d want 1/1", pass_cnt[31:16], fail_cnt[31:16]);
    end
  endtask

  task automatic test_boundary();
    do_clr();
    vectors++;
    if (err_sticky !== 4'b0000 || fail_cnt !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_sticky got sticky=%b fail=%h want 0", err_sticky, fail_cnt);
    end
    toggle(2);
    tick(20);
    toggle(2);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[47:32] !== 16'd1 || fail_cnt[47:32] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL bound_20 got pass=%0d fail=%0d want 1/0", pass_cnt[47:32], fail_cnt[47:32]);
    end
    tick(19 - LAT - 1);
    toggle(2);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[47:32] !== 16'd1 || fail_cnt[47:32] !== 16'd1 || err_sticky !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL bound_19 got pass=%0d fail=%0d sticky=%b want 1/1/0100",
               pass_cnt[47:32], fail_cnt[47:32], err_sticky);
    end
  endtask

  task automatic test_mask();
    do_clr();
    ch_mask = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      toggle(3);
      tick(5);
    end
    vectors++;
    if (pass_cnt[63:48] !== 16'd0 || fail_cnt[63:48] !== 16'd0 || err_sticky[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mask_off got pass=%0d fail=%0d sticky3=%b want 0/0/0",
               pass_cnt[63:48], fail_cnt[63:48], err_sticky[3]);
    end
    ch_mask = 4'hF;
    tick(2);
    toggle(3);
    tick(5);
    vectors++;
    if (fail_cnt[63:48] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL mask_ref got fail=%0d want 0", fail_cnt[63:48]);
    end
    toggle(3);
    tick(LAT + 1);
    vectors++;
    if (fail_cnt[63:48] !== 16'd1 || pass_cnt[63:48] !== 16'd0 || err_sticky !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL mask_on got fail=%0d pass=%0d sticky=%b want 1/0/1000",
               fail_cnt[63:48], pass_cnt[63:48], err_sticky);
    end
  endtask

  task automatic test_saturation_clear();
    do_clr();
    for (int i = 0; i < 21; i++) begin
      toggle(0);
      tick(21);
    end
    vectors++;
    if (s_pass_cnt[3:0] !== 4'd15) begin
      miscompares++;
      $display("[TB] FAIL sat_small got %0d want 15", s_pass_cnt[3:0]);
    end
    vectors++;
    if (pass_cnt[15:0] !== 16'd20) begin
      miscompares++;
      $display("[TB] FAIL sat_wide got %0d want 20", pass_cnt[15:0]);
    end
    toggle(0);
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if (pass_cnt !== 64'd0 || fail_cnt !== 64'd0 || err_sticky !== 4'b0 || s_pass_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_edge got pass=%h fail=%h sticky=%b spass=%h want 0",
               pass_cnt, fail_cnt, err_sticky, s_pass_cnt);
    end
    tick(21 - LAT);
    toggle(0);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[15:0] !== 16'd0 || fail_cnt[15:0] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_noref got pass=%0d fail=%0d want 0/0", pass_cnt[15:0], fail_cnt[15:0]);
    end
    tick(21 - LAT - 1);
    toggle(0);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[15:0] !== 16'd1 || s_pass_cnt[3:0] !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL clr_resume got pass=%0d spass=%0d want 1/1", pass_cnt[15:0], s_pass_cnt[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    sig_in = '0;
    tick(30);
    do_clr();
    toggle(1);
    tick(25);
    toggle(1);
    tick(3);
    toggle(1);
    tick(25);
    toggle(1);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[31:16] !== 16'd2 || fail_cnt[31:16] !== 16'd1 || err_sticky !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL rmid_pre got pass=%0d fail=%0d sticky=%b want 2/1/0010",
               pass_cnt[31:16], fail_cnt[31:16], err_sticky);
    end
    tick(5);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (pass_cnt !== 64'd0 || fail_cnt !== 64'd0 || err_sticky !== 4'b0 || err_pulse !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL rmid_async got pass=%h fail=%h sticky=%b pulse=%b want 0",
               pass_cnt, fail_cnt, err_sticky, err_pulse);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    tick(2);
    toggle(1);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[31:16] !== 16'd0 || fail_cnt[31:16] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rmid_ref got pass=%0d fail=%0d want 0/0", pass_cnt[31:16], fail_cnt[31:16]);
    end
    tick(25 - LAT - 1);
    toggle(1);
    tick(LAT + 1);
    vectors++;
    if (pass_cnt[31:16] !== 16'd1 || fail_cnt[31:16] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rmid_after got pass=%0d fail=%0d want 1/0", pass_cnt[31:16], fail_cnt[31:16]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_glitch();
    test_boundary();
    test_mask();
    test_saturation_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
